// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: fetch FSM states, bubble word,
// PC increment and the IF/ID field widths.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  localparam int          INSTR_W   = 32;
  localparam int          NPC_W     = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load enable plus flush-to-bubble (flush wins).
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP = NOP_INSTR
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_flush,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [NPC_W-1:0]   i_npc,
  output logic [INSTR_W-1:0] o_instr,
  output logic [NPC_W-1:0]   o_npc,
  output logic               o_valid
);

  logic [INSTR_W-1:0] r_instr;
  logic [NPC_W-1:0]   r_npc;
  logic               r_valid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_instr <= NOP;
      r_npc   <= '0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_instr <= NOP;
      r_npc   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_npc   <= i_npc;
      r_valid <= 1'b1;
    end
  end

  assign o_instr = r_instr;
  assign o_npc   = r_npc;
  assign o_valid = r_valid;

endmodule

// File: rtl/i_fetch.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ready handshake,
// absorbs stalls in a one-entry hold buffer and flushes on redirect.
module i_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_out,
  output logic [31:0] npc_out,
  output logic        valid_out,
  output logic [31:0] pc_out
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_fetch_addr;
  logic [31:0]  r_buf;

  logic [31:0]  w_target;
  logic [31:0]  w_next_seq;
  logic         w_load;
  logic         w_flush;
  logic [31:0]  w_ifid_instr;

  assign w_target   = align_word(redirect_target);
  assign w_next_seq = r_fetch_addr + PC_STEP;

  always_comb begin
    w_load       = 1'b0;
    w_flush      = 1'b0;
    w_ifid_instr = imem_rdata;
    case (r_state)
      ST_REQ: begin
        if (redirect)          w_flush = 1'b1;
        else if (imem_ready)   w_load  = !stall;
        else                   w_flush = !stall;
      end
      ST_HOLD: begin
        w_ifid_instr = r_buf;
        if (redirect)          w_flush = 1'b1;
        else                   w_load  = !stall;
      end
      default:                 w_flush = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= ST_REQ;
      r_pc         <= RESET_PC;
      r_fetch_addr <= RESET_PC;
      r_buf        <= '0;
    end else begin
      case (r_state)
        ST_REQ: begin
          if (redirect) begin
            r_pc <= w_target;
            if (imem_ready) r_fetch_addr <= w_target;
            else            r_state      <= ST_DRAIN;
          end else if (imem_ready) begin
            if (stall) begin
              r_buf   <= imem_rdata;
              r_state <= ST_HOLD;
            end else begin
              r_pc         <= w_next_seq;
              r_fetch_addr <= w_next_seq;
            end
          end
        end
        ST_HOLD: begin
          if (redirect) begin
            r_pc         <= w_target;
            r_fetch_addr <= w_target;
            r_state      <= ST_REQ;
          end else if (!stall) begin
            r_pc         <= w_next_seq;
            r_fetch_addr <= w_next_seq;
            r_state      <= ST_REQ;
          end
        end
        ST_DRAIN: begin
          // The stale request keeps its address; only its completion retargets.
          if (redirect) r_pc <= w_target;
          if (imem_ready) begin
            r_fetch_addr <= redirect ? w_target : r_pc;
            r_state      <= ST_REQ;
          end
        end
        default: r_state <= ST_REQ;
      endcase
    end
  end

  if_id_reg #(.NOP(NOP_INSTR)) u_if_id (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_load  (w_load),
    .i_flush (w_flush),
    .i_instr (w_ifid_instr),
    .i_npc   (w_next_seq),
    .o_instr (instruction_out),
    .o_npc   (npc_out),
    .o_valid (valid_out)
  );

  assign imem_req  = (r_state != ST_HOLD) && !RST;
  assign imem_addr = r_fetch_addr;
  assign pc_out    = r_pc;

endmodule

// File: tb/tb_i_fetch.sv
// Bench for i_fetch: directed vector table, randomized run against a
// transaction-level model, and a wrap/async-reset sequence on a second instance.
module tb_i_fetch;

  localparam logic [31:0] K = 32'hA5A5_0000;
  localparam logic [31:0] J = 32'hDEAD_BEEF;

  logic        CLK;
  logic        RST, stall, redirect, imem_ready;
  logic [31:0] redirect_target, imem_rdata;
  logic        imem_req, valid_out;
  logic [31:0] imem_addr, instruction_out, npc_out, pc_out;

  logic        RST2, stall2, redirect2, imem_ready2;
  logic [31:0] redirect_target2, imem_rdata2;
  logic        imem_req2, valid_out2;
  logic [31:0] imem_addr2, instruction_out2, npc_out2, pc_out2;

  int errs   = 0;
  int checks = 0;

  i_fetch dut (
    .CLK(CLK), .RST(RST), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instruction_out(instruction_out), .npc_out(npc_out),
    .valid_out(valid_out), .pc_out(pc_out)
  );

  i_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .CLK(CLK), .RST(RST2), .stall(stall2), .redirect(redirect2),
    .redirect_target(redirect_target2), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ready(imem_ready2), .imem_rdata(imem_rdata2),
    .instruction_out(instruction_out2), .npc_out(npc_out2),
    .valid_out(valid_out2), .pc_out(pc_out2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        st;
    logic        rd;
    logic [31:0] tgt;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic        e_v;
    logic [31:0] e_ins;
    logic [31:0] e_npc;
  } vec_t;

  vec_t tbl[22];

  // reference model state
  logic [31:0] m_pc, m_fa, m_buf, m_ins, m_npc, tgt;
  logic        m_hbuf, m_stale, m_v, req_p, rdy;
  int          mcnt, mlat;

  task automatic m_deliver(input logic [31:0] w);
    m_ins = w;
    m_npc = m_fa + 32'd4;
    m_v   = 1'b1;
    m_fa  = m_fa + 32'd4;
    m_pc  = m_fa;
  endtask

  task automatic m_bubble();
    m_ins = 32'h0;
    m_v   = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{0, 0, 0,      1, K ^ 32'h0,   1, 32'h4,   32'h4,   1, K ^ 32'h0,   32'h4};
    tbl[1]  = '{0, 0, 0,      1, K ^ 32'h4,   1, 32'h8,   32'h8,   1, K ^ 32'h4,   32'h8};
    tbl[2]  = '{0, 0, 0,      1, K ^ 32'h8,   1, 32'hC,   32'hC,   1, K ^ 32'h8,   32'hC};
    tbl[3]  = '{0, 0, 0,      1, K ^ 32'hC,   1, 32'h10,  32'h10,  1, K ^ 32'hC,   32'h10};
    tbl[4]  = '{1, 0, 0,      1, K ^ 32'h10,  0, 32'h10,  32'h10,  1, K ^ 32'hC,   32'h10};
    tbl[5]  = '{1, 0, 0,      0, J,           0, 32'h10,  32'h10,  1, K ^ 32'hC,   32'h10};
    tbl[6]  = '{1, 0, 0,      0, J,           0, 32'h10,  32'h10,  1, K ^ 32'hC,   32'h10};
    tbl[7]  = '{1, 0, 0,      0, J,           0, 32'h10,  32'h10,  1, K ^ 32'hC,   32'h10};
    tbl[8]  = '{0, 0, 0,      0, J,           1, 32'h14,  32'h14,  1, K ^ 32'h10,  32'h14};
    tbl[9]  = '{0, 0, 0,      0, J,           1, 32'h14,  32'h14,  0, 32'h0,       32'h0};
    tbl[10] = '{0, 0, 0,      0, J,           1, 32'h14,  32'h14,  0, 32'h0,       32'h0};
    tbl[11] = '{0, 0, 0,      1, K ^ 32'h14,  1, 32'h18,  32'h18,  1, K ^ 32'h14,  32'h18};
    tbl[12] = '{0, 1, 32'h103, 0, J,          1, 32'h18,  32'h100, 0, 32'h0,       32'h0};
    tbl[13] = '{0, 0, 0,      0, J,           1, 32'h18,  32'h100, 0, 32'h0,       32'h0};
    tbl[14] = '{0, 0, 0,      1, K ^ 32'h18,  1, 32'h100, 32'h100, 0, 32'h0,       32'h0};
    tbl[15] = '{0, 0, 0,      0, J,           1, 32'h100, 32'h100, 0, 32'h0,       32'h0};
    tbl[16] = '{0, 0, 0,      1, K ^ 32'h100, 1, 32'h104, 32'h104, 1, K ^ 32'h100, 32'h104};
    tbl[17] = '{1, 0, 0,      1, K ^ 32'h104, 0, 32'h104, 32'h104, 1, K ^ 32'h100, 32'h104};
    tbl[18] = '{1, 1, 32'h200, 0, J,          1, 32'h200, 32'h200, 0, 32'h0,       32'h0};
    tbl[19] = '{0, 0, 0,      1, K ^ 32'h200, 1, 32'h204, 32'h204, 1, K ^ 32'h200, 32'h204};
    tbl[20] = '{0, 1, 32'h37, 1, K ^ 32'h204, 1, 32'h34,  32'h34,  0, 32'h0,       32'h0};
    tbl[21] = '{0, 0, 0,      1, K ^ 32'h34,  1, 32'h38,  32'h38,  1, K ^ 32'h34,  32'h38};

    RST = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = '0;
    imem_ready = 1'b0; imem_rdata = '0;
    RST2 = 1'b1; stall2 = 1'b0; redirect2 = 1'b0; redirect_target2 = '0;
    imem_ready2 = 1'b1; imem_rdata2 = '0;

    repeat (2) @(posedge CLK);
    #1;
    chk("rst_req",   {31'b0, imem_req}, 32'h0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_pc",    pc_out, 32'h0);
    chk("rst_valid", {31'b0, valid_out}, 32'h0);
    chk("rst_instr", instruction_out, 32'h0);
    chk("rst_npc",   npc_out, 32'h0);
    RST = 1'b0;
    #1;
    chk("post_rst_req", {31'b0, imem_req}, 32'h1);

    for (int i = 0; i < 22; i++) begin
      stall = tbl[i].st; redirect = tbl[i].rd; redirect_target = tbl[i].tgt;
      imem_ready = tbl[i].rdy; imem_rdata = tbl[i].rdata;
      @(posedge CLK); #1;
      chk($sformatf("v%0d_req", i),   {31'b0, imem_req}, {31'b0, tbl[i].e_req});
      chk($sformatf("v%0d_addr", i),  imem_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_pc", i),    pc_out, tbl[i].e_pc);
      chk($sformatf("v%0d_valid", i), {31'b0, valid_out}, {31'b0, tbl[i].e_v});
      chk($sformatf("v%0d_instr", i), instruction_out, tbl[i].e_ins);
      if (tbl[i].e_v) chk($sformatf("v%0d_npc", i), npc_out, tbl[i].e_npc);
    end

    // Randomized run after a mid-cycle asynchronous reset.
    #2 RST = 1'b1;
    #1 chk("arst_valid", {31'b0, valid_out}, 32'h0);
    chk("arst_addr", imem_addr, 32'h0);
    @(posedge CLK); #1;
    RST = 1'b0;
    m_pc = 0; m_fa = 0; m_buf = 0; m_ins = 0; m_npc = 0;
    m_hbuf = 0; m_stale = 0; m_v = 0; mcnt = 0; mlat = $urandom_range(0, 3);
    for (int c = 0; c < 1500; c++) begin
      req_p           = !m_hbuf;
      stall           = ($urandom_range(0, 3) == 0);
      redirect        = ($urandom_range(0, 9) == 0);
      redirect_target = $urandom;
      rdy             = req_p && (mcnt == mlat);
      imem_ready      = rdy;
      imem_rdata      = rdy ? (m_fa ^ K) : $urandom;
      tgt             = {redirect_target[31:2], 2'b00};
      if (m_stale) begin
        if (redirect) m_pc = tgt;
        if (rdy) begin m_fa = m_pc; m_stale = 1'b0; end
        m_bubble();
      end else if (m_hbuf) begin
        if (redirect) begin
          m_pc = tgt; m_fa = tgt; m_hbuf = 1'b0; m_bubble();
        end else if (!stall) begin
          m_deliver(m_buf); m_hbuf = 1'b0;
        end
      end else begin
        if (redirect) begin
          m_bubble(); m_pc = tgt;
          if (rdy) m_fa = tgt; else m_stale = 1'b1;
        end else if (rdy) begin
          if (stall) begin m_buf = imem_rdata; m_hbuf = 1'b1; end
          else m_deliver(imem_rdata);
        end else if (!stall) m_bubble();
      end
      if (req_p) begin
        if (rdy) begin mcnt = 0; mlat = $urandom_range(0, 3); end
        else mcnt++;
      end
      @(posedge CLK); #1;
      chk($sformatf("r%0d_req", c),   {31'b0, imem_req}, {31'b0, !m_hbuf});
      chk($sformatf("r%0d_addr", c),  imem_addr, m_fa);
      chk($sformatf("r%0d_pc", c),    pc_out, m_pc);
      chk($sformatf("r%0d_valid", c), {31'b0, valid_out}, {31'b0, m_v});
      chk($sformatf("r%0d_instr", c), instruction_out, m_ins);
      if (m_v) chk($sformatf("r%0d_npc", c), npc_out, m_npc);
    end

    // Wrap at 2^32 and asynchronous reset in the middle of a request.
    RST2 = 1'b0; imem_ready2 = 1'b1; imem_rdata2 = 32'h1111_0000;
    #1;
    chk("w_req0",  {31'b0, imem_req2}, 32'h1);
    chk("w_addr0", imem_addr2, 32'hFFFF_FFFC);
    @(posedge CLK); #1;
    chk("w_valid1", {31'b0, valid_out2}, 32'h1);
    chk("w_instr1", instruction_out2, 32'h1111_0000);
    chk("w_npc1",   npc_out2, 32'h0);
    chk("w_addr1",  imem_addr2, 32'h0);
    chk("w_pc1",    pc_out2, 32'h0);
    imem_rdata2 = 32'h2222_0000;
    @(posedge CLK); #1;
    chk("w_npc2",  npc_out2, 32'h4);
    chk("w_addr2", imem_addr2, 32'h4);
    imem_ready2 = 1'b0;
    @(posedge CLK); #1;
    chk("w_bubble", {31'b0, valid_out2}, 32'h0);
    chk("w_pend_req", {31'b0, imem_req2}, 32'h1);
    #2 RST2 = 1'b1;
    #1;
    chk("w_arst_req",   {31'b0, imem_req2}, 32'h0);
    chk("w_arst_addr",  imem_addr2, 32'hFFFF_FFFC);
    chk("w_arst_pc",    pc_out2, 32'hFFFF_FFFC);
    chk("w_arst_valid", {31'b0, valid_out2}, 32'h0);
    chk("w_arst_instr", instruction_out2, 32'h0);
    chk("w_arst_npc",   npc_out2, 32'h0);
    imem_ready2 = 1'b1; imem_rdata2 = 32'h3333_0000;
    @(posedge CLK); #1;
    chk("w_hold_valid", {31'b0, valid_out2}, 32'h0);
    chk("w_hold_addr",  imem_addr2, 32'hFFFF_FFFC);
    RST2 = 1'b0; imem_rdata2 = 32'h4444_0000;
    @(posedge CLK); #1;
    chk("w_rel_instr", instruction_out2, 32'h4444_0000);
    chk("w_rel_npc",   npc_out2, 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/i_fetch.md
Name: i_fetch

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the decode stage.
- Owns the PC and fetches words from instruction memory over a req/ready handshake.
- Holds the IF/ID pipeline register that drives decode's instruction_in/npc_in.
- Handles stall (hold) and redirect (branch/jump flush) requests from downstream.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, bubble word (sll $0,$0,0) written into IF/ID on flush/reset

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous, active-high reset
stall  input  1  hazard unit: hold PC and IF/ID
redirect  input  1  taken branch or jump resolved downstream
redirect_target  input  32  new PC when redirect=1
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  word address of the outstanding request
imem_ready  input  1  imem_rdata valid this cycle; completes the request
imem_rdata  input  32  fetched instruction word
instruction_out  output  32  IF/ID instruction, feeds decode instruction_in
npc_out  output  32  IF/ID PC+4, feeds decode npc_in
valid_out  output  1  IF/ID holds a real instruction (0 = bubble)
pc_out  output  32  current PC, debug/visibility

Behaviour:
- Reset (async, RST=1) values:
  - pc=RESET_PC; fetch_addr=RESET_PC; state=REQ; imem_req=0 while RST is high.
  - instruction_out=NOP_INSTR; npc_out=0; valid_out=0; hold buffer=0.
- imem_addr = fetch_addr (registered). It is stable for the whole of a request.
- imem_req=1 in REQ and DRAIN, 0 in HOLD.
- Memory contract:
  - Non-pipelined: one outstanding request at a time.
  - Response arrives when imem_ready=1, 1..N cycles after the request starts.
  - Zero-wait memory: imem_ready=1 in the first request cycle gives one instruction per cycle.
- Priority: redirect > stall > normal advance.
- FSM, state REQ:
  - ready=1, redirect=0, stall=0: IF/ID <= {imem_rdata, fetch_addr+4, valid=1}; pc, fetch_addr <= fetch_addr+4; stay REQ.
  - ready=1, redirect=0, stall=1: buffer <= imem_rdata; IF/ID unchanged; go HOLD.
  - ready=0, redirect=0: keep the request; IF/ID updates only if stall=0, and then as a bubble (valid=0, NOP_INSTR).
  - redirect=1, ready=1: response discarded; pc, fetch_addr <= {redirect_target[31:2], 2'b00}; IF/ID <= bubble; stay REQ.
  - redirect=1, ready=0: pc <= aligned target; fetch_addr unchanged; IF/ID <= bubble; go DRAIN.
- FSM, state HOLD:
  - redirect=1: buffer dropped; pc, fetch_addr <= aligned target; IF/ID <= bubble; go REQ.
  - stall=0: IF/ID <= {buffer, fetch_addr+4, valid=1}; pc, fetch_addr <= fetch_addr+4; go REQ.
  - stall=1: no change.
- FSM, state DRAIN (waiting out a stale request):
  - ready=1: data discarded; fetch_addr <= pc; go REQ.
  - A further redirect in DRAIN updates pc only; the latest target wins.
  - IF/ID stays bubble.
- Alignment: redirect_target[1:0] is ignored and forced to 00.
- Address arithmetic is modulo 2^32: PC 32'hFFFF_FFFC wraps to 0. npc_out wraps the same way.
- Stall never loses a fetched word. The hold buffer is exactly one entry.
- Redirect always clears IF/ID, even with stall=1.
- Reset asserted mid-request: everything returns to reset values immediately. Any memory response arriving after reset is ignored until a new request is issued.

Decomposition:
- Shared package mips_pkg:
  - fetch FSM state enum {REQ, HOLD, DRAIN}
  - NOP_INSTR constant
  - PC_STEP=4 constant
  - the IF/ID field widths
- One natural sub-module: if_id_reg. It is the IF/ID register with load enable and a flush-to-bubble input, mirroring how ID_EX is used by decode.
- The FSM and PC logic stay in i_fetch.

Test Plan:
- Reset, zero-wait memory (ready=1 always), rdata=addr^32'hA5A5_0000 → after 3 edges: IF/ID holds fetch from 8, npc_out=12, valid_out=1, imem_addr=12.
- 3-cycle-latency memory, no stall → a bubble (valid_out=0) on each wait cycle; the word arrives with npc_out=fetch_addr+4; pc advances by 4 only per response.
- stall=1 asserted the same cycle as ready at addr 0x10 for 4 cycles → imem_req=0 and IF/ID frozen during the stall. One cycle after release: instruction_out=word@0x10, npc_out=0x14, and the next request is addr 0x14.
- redirect=1, target=0x0000_0103, while a 3-cycle request is pending (DRAIN) → stale word discarded; next imem_addr=0x100; valid_out=0 until the 0x100 word arrives with npc_out=0x104.
- redirect and stall together in HOLD → IF/ID becomes a bubble, the buffer is dropped, and the next fetch is at the target.
- RESET_PC=32'hFFFF_FFFC, zero-wait memory → second fetch address is 0; npc_out of the first instruction is 0. Then assert RST mid-request → outputs return to reset values asynchronously, before the next edge.
